registry_dump: RTL and testbench

REGISTRY_DUMP -- requirements
Module: registry_dump

---
 rtl/registry_dump.sv | 105 ++++++++++
 tb/tb_registry_dump.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/registry_dump.sv
// Serialises a snapshot of a nibble-wide register file into UART bytes {index, value},
// optionally skipping registers whose value has not changed since it was last sent.
module registry_dump #(
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_REG_WIDTH       = 4
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [(2**(C_UART_DATA_WIDTH-C_REG_WIDTH))*C_REG_WIDTH-1:0] register,
    input  logic                                                         start,
    input  logic                                                         changed,
    input  logic                                                         busy,
    output logic [C_UART_DATA_WIDTH-1:0]                                 data,
    output logic                                                         send,
    output logic                                                         active,
    output logic                                                         done
);

    localparam int C_REG_COUNT_WIDTH = C_UART_DATA_WIDTH - C_REG_WIDTH;
    localparam int C_REG_COUNT       = 2**C_REG_COUNT_WIDTH;
    localparam int C_REG_PORT_WIDTH  = C_REG_COUNT * C_REG_WIDTH;
    localparam logic [C_REG_COUNT_WIDTH-1:0] LAST_INDEX = {C_REG_COUNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {IDLE, SCAN, SEND, WAITH, WAITL, DONE} state_t;

    state_t                         state;
    logic [C_REG_COUNT_WIDTH-1:0]   index;
    logic                           mode_changed;
    logic                           primed;
    logic [C_REG_WIDTH-1:0]         shadow [C_REG_COUNT];
    logic [C_REG_WIDTH-1:0]         last   [C_REG_COUNT];

    // The shadow copy decouples the dump from the live register file, so bytes of one
    // dump always describe the same instant; last[] remembers what the receiver holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            index        <= '0;
            mode_changed <= 1'b0;
            primed       <= 1'b0;
            data         <= '0;
            send         <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < C_REG_COUNT; i++) begin
                shadow[i] <= '0;
                last[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < C_REG_COUNT; i++)
                            shadow[i] <= register[i*C_REG_WIDTH +: C_REG_WIDTH];
                        mode_changed <= changed;
                        index        <= '0;
                        active       <= 1'b1;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (!mode_changed || !primed || shadow[index] != last[index]) begin
                        data         <= {index, shadow[index]};
                        last[index]  <= shadow[index];
                        send         <= 1'b1;
                        state        <= SEND;
                    end else if (index == LAST_INDEX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                SEND: begin
                    send  <= 1'b0;
                    state <= WAITH;
                end
                WAITH: begin
                    if (busy)
                        state <= WAITL;
                end
                // No timeout here: a transmitter that never frees up stalls the dump on purpose.
                WAITL: begin
                    if (!busy) begin
                        if (index == LAST_INDEX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            index <= index + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    active <= 1'b0;
                    primed <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_registry_dump.sv
// Testbench for registry_dump: a small UART Tx model answers send strobes with busy,
// and a queue-based reference model predicts the byte stream of each dump.
module tb_registry_dump;

    localparam logic [63:0] REGV = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] register = '0;
    logic        start = 1'b0;
    logic        changed = 1'b0;
    logic        busy = 1'b0;
    logic [7:0]  data;
    logic        send;
    logic        active;
    logic        done;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int start_edge = 0;
    int first_send_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int active_cnt = 0;
    logic [7:0] sent_q[$];

    logic [7:0] exp_q[$];
    logic [3:0] ref_last [16];
    bit         ref_primed = 1'b0;

    bit stuck = 1'b0;
    bit tx_pend = 1'b0;
    int tx_left = 0;

    registry_dump dut (
        .clk      (clk),
        .rst      (rst),
        .register (register),
        .start    (start),
        .changed  (changed),
        .busy     (busy),
        .data     (data),
        .send     (send),
        .active   (active),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART Tx model: busy rises one cycle after a send strobe and stays high 10 cycles
    always @(negedge clk) begin
        if (tx_pend) begin
            tx_pend = 1'b0;
            busy = 1'b1;
            tx_left = 10;
        end else if (stuck) begin
            busy = 1'b1;
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) busy = 1'b0;
        end else begin
            busy = 1'b0;
        end
        if (send) tx_pend = 1'b1;
    end

    always @(negedge clk) begin
        if (send) begin
            sent_q.push_back(data);
            if (first_send_cyc < 0) first_send_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (active) active_cnt++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: which bytes a dump of snapshot v must emit, in order
    task automatic model_dump(input logic [63:0] v, input bit mode);
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] nib;
            nib = v[i*4 +: 4];
            if (!mode || !ref_primed || nib != ref_last[i]) begin
                exp_q.push_back({i[3:0], nib});
                ref_last[i] = nib;
            end
        end
        ref_primed = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_last[i] = 4'h0;
        ref_primed = 1'b0;
    endtask

    task automatic pulse_start(input logic [63:0] v, input bit mode);
        tick();
        register = v;
        changed = mode;
        start = 1'b1;
        sent_q.delete();
        done_cnt = 0;
        active_cnt = 0;
        first_send_cyc = -1;
        done_cyc = -1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic run_dump(input logic [63:0] v, input bit mode, input bit scramble,
                            input int budget, output bit ok);
        pulse_start(v, mode);
        if (scramble) register = {$urandom, $urandom};
        wait_done(budget, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (send !== 1'b0)   begin errors++; $display("[TB] FAIL reset_send: got %b expected 0", send); end
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
        checks++; if (done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (data !== 8'h00)  begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
        rst = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL idle_active: got %b expected 0", active); end
    endtask

    task automatic test_dump_all();
        bit ok;
        logic [7:0] got;
        model_dump(REGV, 1'b0);
        run_dump(REGV, 1'b0, 1'b0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL all_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== 16) begin errors++; $display("[TB] FAIL all_count: got %0d expected 16", sent_q.size()); end
        for (int i = 0; i < 16; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++;
            if (got !== 8'(i * 17)) begin
                errors++; $display("[TB] FAIL all_byte%0d: got %h expected %h", i, got, 8'(i * 17));
            end
        end
        checks++; if (first_send_cyc - start_edge !== 1) begin errors++; $display("[TB] FAIL all_latency: got cycle k+%0d expected k+2", first_send_cyc - start_edge + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL all_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_changed_one();
        bit ok;
        logic [63:0] v;
        v = REGV;
        v[5*4 +: 4] = 4'h0;
        model_dump(v, 1'b1);
        run_dump(v, 1'b1, 1'b0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL one_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== 1) begin errors++; $display("[TB] FAIL one_count: got %0d expected 1", sent_q.size()); end
        checks++; if (sent_q.size() > 0 && sent_q[0] !== 8'h50) begin errors++; $display("[TB] FAIL one_byte: got %h expected 50", sent_q[0]); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL one_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_changed_none();
        bit ok;
        logic [63:0] v;
        v = REGV;
        v[5*4 +: 4] = 4'h0;
        model_dump(v, 1'b1);
        run_dump(v, 1'b1, 1'b0, 100, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL none_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL none_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
        checks++; if (done_cyc - start_edge !== 16) begin errors++; $display("[TB] FAIL none_done_latency: got cycle k+%0d expected k+17", done_cyc - start_edge + 1); end
        checks++; if (active_cnt !== 17) begin errors++; $display("[TB] FAIL none_active_cycles: got %0d expected 17", active_cnt); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        model_dump(REGV, 1'b0);
        pulse_start(REGV, 1'b0);
        for (int n = 0; n < 200 && sent_q.size() < 3; n++) tick();
        for (int p = 0; p < 3; p++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat ($urandom_range(1, 20)) tick();
        end
        wait_done(1000, ok);
        repeat (40) tick();
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ign_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL ign_count: got %0d expected %0d", sent_q.size(), exp_q.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL ign_done_count: got %0d expected 1", done_cnt); end
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL ign_active: got %b expected 0", active); end
    endtask

    task automatic test_random();
        bit ok;
        bit mode;
        logic [63:0] v;
        logic [7:0] got;
        v = REGV;
        for (int it = 0; it < 6; it++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--)
                v[$urandom_range(0, 15)*4 +: 4] = 4'($urandom);
            mode = 1'($urandom_range(0, 1));
            model_dump(v, mode);
            run_dump(v, mode, 1'b1, 1000, ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rnd%0d_timeout: got no done, expected done", it); end
            checks++; if (sent_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", it, sent_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
                checks++;
                if (got !== exp_q[i]) begin
                    errors++; $display("[TB] FAIL rnd%0d_byte%0d: got %h expected %h", it, i, got, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int done_before;
        logic [7:0] got;
        pulse_start(REGV, 1'b0);
        for (int n = 0; n < 500 && !(sent_q.size() >= 4 && busy); n++) tick();
        repeat (2) tick();
        done_before = done_cnt;
        rst = 1'b1;
        tick();
        checks++; if (send !== 1'b0)   begin errors++; $display("[TB] FAIL mid_send: got %b expected 0", send); end
        checks++; if (active !== 1'b0) begin errors++; $display("[TB] FAIL mid_active: got %b expected 0", active); end
        checks++; if (done_cnt !== done_before || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %0d pulses expected %0d", done_cnt, done_before); end
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 50 && busy; n++) tick();
        model_dump(REGV, 1'b1);
        run_dump(REGV, 1'b1, 1'b0, 1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== 16) begin errors++; $display("[TB] FAIL mid_count: got %0d expected 16", sent_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                errors++; $display("[TB] FAIL mid_byte%0d: got %h expected %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_stuck();
        bit ok;
        model_dump(REGV, 1'b0);
        pulse_start(REGV, 1'b0);
        for (int n = 0; n < 20 && sent_q.size() < 1; n++) tick();
        checks++; if (sent_q.size() !== 1) begin errors++; $display("[TB] FAIL stuck_first: got %0d bytes expected 1", sent_q.size()); end
        stuck = 1'b1;
        repeat (1000) tick();
        checks++; if (sent_q.size() !== 1) begin errors++; $display("[TB] FAIL stuck_hold: got %0d bytes expected 1", sent_q.size()); end
        checks++; if (active !== 1'b1) begin errors++; $display("[TB] FAIL stuck_active: got %b expected 1", active); end
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL stuck_done: got %0d expected 0", done_cnt); end
        stuck = 1'b0;
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stuck_timeout: got no done, expected done"); end
        checks++; if (sent_q.size() !== 16) begin errors++; $display("[TB] FAIL stuck_count: got %0d expected 16", sent_q.size()); end
        checks++; if (sent_q.size() > 1 && sent_q[1] !== 8'h11) begin errors++; $display("[TB] FAIL stuck_resume: got %h expected 11", sent_q[1]); end
    endtask

    initial begin
        $display("[TB] registry_dump bench start");
        test_reset();
        test_dump_all();
        test_changed_one();
        test_changed_none();
        test_start_ignored();
        test_random();
        test_reset_mid();
        test_stuck();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
